proc_ctrl_fsm: RTL and testbench

- Control unit for the simple multi-cycle processor datapath.
- Latches a 9-bit instruction (III XXX YYY) from DIN and sequences it over timesteps T0..T3.
- Drives register-select index and enable pairs (Rin_idx/Rin_en, Rout_idx/Rout_en) straight into the 3-to-8 register-enable decoders. Also drives the A/G register loads, the bus-source selects and the add/sub control.

---
 rtl/proc_ctrl_fsm.sv | 123 ++++++++++++
 tb/tb_proc_ctrl_fsm.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/proc_ctrl_fsm.sv
// Control FSM for the multi-cycle processor datapath: latches a 9-bit
// instruction (III XXX YYY) and sequences mv/mvi/add/sub over T0..T3.
module proc_ctrl_fsm #(
   parameter int DATA_W = 16
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Run,
   input  logic [DATA_W-1:0] DIN,
   output logic              IRin,
   output logic [2:0]        Rin_idx,
   output logic              Rin_en,
   output logic [2:0]        Rout_idx,
   output logic              Rout_en,
   output logic              DINout,
   output logic              Gout,
   output logic              Ain,
   output logic              Gin,
   output logic              AddSub,
   output logic              Done,
   output logic              Busy
);

   typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

   state_t     state_q, state_d;
   logic [8:0] ir_q;
   logic [2:0] op, rx, ry;
   logic       is_arith;
   logic       unused_din;

   assign op         = ir_q[8:6];
   assign rx         = ir_q[5:3];
   assign ry         = ir_q[2:0];
   assign is_arith   = (op == OP_ADD) || (op == OP_SUB);
   // Only DIN[8:0] carries the instruction; the rest is datapath-only.
   assign unused_din = ^DIN;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= T0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == T0 && Run)
            ir_q <= DIN[8:0];
      end
   end

   always_comb begin
      state_d  = T0;
      IRin     = 1'b0;
      Rin_idx  = 3'd0;
      Rin_en   = 1'b0;
      Rout_idx = 3'd0;
      Rout_en  = 1'b0;
      DINout   = 1'b0;
      Gout     = 1'b0;
      Ain      = 1'b0;
      Gin      = 1'b0;
      AddSub   = 1'b0;
      Done     = 1'b0;
      Busy     = 1'b0;
      case (state_q)
         T0: begin
            IRin    = Run;
            state_d = Run ? T1 : T0;
         end
         T1: begin
            Busy = 1'b1;
            case (op)
               OP_MV: begin
                  Rout_en  = 1'b1;
                  Rout_idx = ry;
                  Rin_en   = 1'b1;
                  Rin_idx  = rx;
                  Done     = 1'b1;
               end
               OP_MVI: begin
                  DINout  = 1'b1;
                  Rin_en  = 1'b1;
                  Rin_idx = rx;
                  Done    = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  Rout_en  = 1'b1;
                  Rout_idx = rx;
                  Ain      = 1'b1;
                  state_d  = T2;
               end
               // Undefined opcodes retire as a nop.
               default: Done = 1'b1;
            endcase
         end
         T2: begin
            Busy = 1'b1;
            if (is_arith) begin
               Rout_en  = 1'b1;
               Rout_idx = ry;
               Gin      = 1'b1;
               AddSub   = (op == OP_SUB);
               state_d  = T3;
            end
         end
         T3: begin
            Busy = 1'b1;
            if (is_arith) begin
               Gout    = 1'b1;
               Rin_en  = 1'b1;
               Rin_idx = rx;
               Done    = 1'b1;
            end
         end
         default: state_d = T0;
      endcase
   end

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Scoreboard bench for proc_ctrl_fsm: stimulus queues hand-computed output
// vectors for each busy cycle; the monitor pops and compares on every busy cycle.
module tb_proc_ctrl_fsm;

   logic        Clock = 1'b0;
   logic        Resetn;
   logic        Run;
   logic [15:0] DIN;
   logic        IRin, Rin_en, Rout_en, DINout, Gout, Ain, Gin, AddSub, Done, Busy;
   logic [2:0]  Rin_idx, Rout_idx;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   logic [15:0] exp_q[$];

   proc_ctrl_fsm #(.DATA_W(16)) dut (
      .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN),
      .IRin(IRin), .Rin_idx(Rin_idx), .Rin_en(Rin_en),
      .Rout_idx(Rout_idx), .Rout_en(Rout_en), .DINout(DINout),
      .Gout(Gout), .Ain(Ain), .Gin(Gin), .AddSub(AddSub),
      .Done(Done), .Busy(Busy)
   );

   always #5 Clock = ~Clock;

   // Packed output vector: {IRin, Rin_en, Rin_idx, Rout_en, Rout_idx,
   //                        DINout, Gout, Ain, Gin, AddSub, Done, Busy}
   function automatic logic [15:0] ov(input logic irin, input logic rin_en,
         input logic [2:0] rin_idx, input logic rout_en, input logic [2:0] rout_idx,
         input logic dinout, input logic gout, input logic ain, input logic gin,
         input logic addsub, input logic done, input logic busy);
      return {irin, rin_en, rin_idx, rout_en, rout_idx, dinout, gout, ain, gin,
              addsub, done, busy};
   endfunction

   logic [15:0] outv;
   assign outv = {IRin, Rin_en, Rin_idx, Rout_en, Rout_idx, DINout, Gout, Ain, Gin,
                  AddSub, Done, Busy};

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: each busy cycle must match the next queued vector.
   always @(negedge Clock) begin
      logic [15:0] e;
      checks++;
      if ((Rout_en + DINout + Gout) > 1) begin
         errors++;
         $display("FAIL bus_excl: Rout_en=%b DINout=%b Gout=%b at %0t",
                  Rout_en, DINout, Gout, $time);
      end
      if (Busy) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL busy_unexpected: got %h expected none at %0t", outv, $time);
         end else begin
            e = exp_q.pop_front();
            if (outv !== e) begin
               errors++;
               $display("FAIL cycle_vec: got %h expected %h at %0t", outv, e, $time);
            end
         end
      end
      if (Done) done_cnt++;
   end

   // Called at posedge+1 in T0; returns at posedge+1 back in T0.
   task automatic run_instr(input string name, input logic [8:0] ins,
                            input logic [15:0] imm, input int ncyc, input logic hold_run);
      DIN = {7'd0, ins};
      Run = 1'b1;
      #1 chk({name, "_irin"}, {15'd0, IRin}, 16'd1);
      @(posedge Clock); #1;
      DIN = imm;
      Run = hold_run;
      repeat (ncyc) begin @(posedge Clock); #1; end
      chk({name, "_idle"}, {15'd0, Busy}, 16'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      Resetn = 1'b0;
      Run    = 1'b1;
      DIN    = 16'h0000;
      repeat (2) @(negedge Clock);
      chk("reset_run1", outv, 16'h8000);
      @(posedge Clock); #1;
      Resetn = 1'b1;
      Run    = 1'b0;
      repeat (5) begin
         @(negedge Clock);
         chk("reset_idle", outv, 16'h0000);
      end
      @(posedge Clock); #1;

      // mvi R3, #A5
      exp_q.push_back(ov(0,1,3'd3,0,3'd0,1,0,0,0,0,1,1));
      run_instr("mvi_r3", 9'b001_011_000, 16'h00A5, 1, 1'b0);

      // mv R5, R2
      exp_q.push_back(ov(0,1,3'd5,1,3'd2,0,0,0,0,0,1,1));
      run_instr("mv_r5_r2", 9'b000_101_010, 16'h0000, 1, 1'b0);

      // sub R1, R6
      exp_q.push_back(ov(0,0,3'd0,1,3'd1,0,0,1,0,0,0,1));
      exp_q.push_back(ov(0,0,3'd0,1,3'd6,0,0,0,1,1,0,1));
      exp_q.push_back(ov(0,1,3'd1,0,3'd0,0,1,0,0,0,1,1));
      run_instr("sub_r1_r6", 9'b011_001_110, 16'h0000, 3, 1'b0);

      // add R2, R2
      exp_q.push_back(ov(0,0,3'd0,1,3'd2,0,0,1,0,0,0,1));
      exp_q.push_back(ov(0,0,3'd0,1,3'd2,0,0,0,1,0,0,1));
      exp_q.push_back(ov(0,1,3'd2,0,3'd0,0,1,0,0,0,1,1));
      run_instr("add_r2_r2", 9'b010_010_010, 16'h0000, 3, 1'b0);

      // Back-to-back with Run held: add R0, R7 then opcode 111 nop
      exp_q.push_back(ov(0,0,3'd0,1,3'd0,0,0,1,0,0,0,1));
      exp_q.push_back(ov(0,0,3'd0,1,3'd7,0,0,0,1,0,0,1));
      exp_q.push_back(ov(0,1,3'd0,0,3'd0,0,1,0,0,0,1,1));
      run_instr("add_r0_r7", 9'b010_000_111, 16'h0000, 3, 1'b1);
      exp_q.push_back(ov(0,0,3'd0,0,3'd0,0,0,0,0,0,1,1));
      run_instr("nop_111", 9'b111_010_011, 16'h0000, 1, 1'b0);

      // Abort: reset pulsed mid-T2 of add R3, R5
      exp_q.push_back(ov(0,0,3'd0,1,3'd3,0,0,1,0,0,0,1));
      DIN = 16'h009D;
      Run = 1'b1;
      @(posedge Clock); #1;
      Run = 1'b0;
      @(posedge Clock); #2;
      chk("abort_t2", outv, ov(0,0,3'd0,1,3'd5,0,0,0,1,0,0,1));
      Resetn = 1'b0;
      #1 chk("abort_drop", outv, 16'h0000);
      @(negedge Clock);
      #2 Resetn = 1'b1;
      @(posedge Clock); #1;
      chk("abort_after", outv, 16'h0000);

      // mvi R4 after the abort
      exp_q.push_back(ov(0,1,3'd4,0,3'd0,1,0,0,0,0,1,1));
      run_instr("mvi_r4", 9'b001_100_000, 16'h1234, 1, 1'b0);

      repeat (3) @(posedge Clock);
      #1;
      chk("queue_empty", 16'(exp_q.size()), 16'd0);
      chk("done_count", 16'(done_cnt), 16'd7);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
